// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the single non-cached I/O bus between the per-core
// request ports. Requests are granted round-robin, one transaction in flight,
// and every transaction (load or store) is answered with a tagged response.
//
// Flat packet layouts:
//   request (per port) = {store, thread_idx[THREAD_IDX_W], address[32], value[32]}
//   response           = {core[4], thread_idx[THREAD_IDX_W], read_value[32]}

`ifndef NUM_CORES
`define NUM_CORES 4
`endif

module io_bus_arbiter #(
    parameter int NUM_REQUESTERS = `NUM_CORES,
    parameter int THREAD_IDX_W   = 2,
    localparam int REQ_W = 1 + THREAD_IDX_W + 64,
    localparam int RSP_W = 4 + THREAD_IDX_W + 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQUESTERS-1:0]       ioreq_valid,
    input  logic [NUM_REQUESTERS*REQ_W-1:0] ioreq_packet,
    output logic [NUM_REQUESTERS-1:0]       ioreq_ready,
    output logic                            iorsp_valid,
    output logic [RSP_W-1:0]                iorsp_packet,
    output logic                            io_write_en,
    output logic                            io_read_en,
    output logic [31:0]                     io_address,
    output logic [31:0]                     io_write_data,
    input  logic [31:0]                     io_read_data
);
    localparam int PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DATA
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [PTR_W-1:0]        r_rrPtr;
    logic [PTR_W-1:0]        r_grantIdx;
    logic [PTR_W-1:0]        w_grantIdx;
    logic [PTR_W-1:0]        w_candIdx;
    logic                    w_anyValid;
    logic                    w_accept;
    logic [REQ_W-1:0]        w_reqPkt;
    logic                    r_store;
    logic [THREAD_IDX_W-1:0] r_threadIdx;

    // Port index base+offset, wrapped modulo the number of requesters.
    function automatic logic [PTR_W-1:0] wrapIdx(input logic [PTR_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQUESTERS) sum = sum - NUM_REQUESTERS;
        return PTR_W'(sum);
    endfunction

    // Find the first valid port at or after the round-robin pointer
    // (scanned backwards so the nearest candidate is the last one written).
    always_comb begin
        w_grantIdx = '0;
        w_anyValid = 1'b0;
        w_candIdx  = '0;
        for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
            w_candIdx = wrapIdx(r_rrPtr, i);
            if (ioreq_valid[w_candIdx]) begin
                w_grantIdx = w_candIdx;
                w_anyValid = 1'b1;
            end
        end
    end

    // Route the granted port's packet to the latch inputs.
    always_comb begin
        w_reqPkt = '0;
        for (int p = 0; p < NUM_REQUESTERS; p++) begin
            if (w_grantIdx == PTR_W'(p)) w_reqPkt = ioreq_packet[p*REQ_W +: REQ_W];
        end
    end

    // Next state and the combinational grant strobe; accepting only while idle
    // and out of reset keeps ready one-hot and silent during a transaction.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        ioreq_ready = '0;
        case (r_state)
            IDLE: begin
                if (w_anyValid && !reset) begin
                    w_accept                = 1'b1;
                    ioreq_ready[w_grantIdx] = 1'b1;
                    w_nextState             = ISSUE;
                end
            end
            ISSUE:     w_nextState = WAIT_DATA;
            WAIT_DATA: w_nextState = IDLE;
            default:   w_nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    // Request latch, registered bus drive for the ISSUE cycle, and the response
    // captured at the end of WAIT_DATA when the slave's read data is valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rrPtr       <= '0;
            r_grantIdx    <= '0;
            r_store       <= 1'b0;
            r_threadIdx   <= '0;
            io_write_en   <= 1'b0;
            io_read_en    <= 1'b0;
            io_address    <= '0;
            io_write_data <= '0;
            iorsp_valid   <= 1'b0;
            iorsp_packet  <= '0;
        end else begin
            io_write_en <= 1'b0;
            io_read_en  <= 1'b0;
            iorsp_valid <= 1'b0;
            if (w_accept) begin
                r_grantIdx    <= w_grantIdx;
                r_rrPtr       <= wrapIdx(w_grantIdx, 1);
                r_store       <= w_reqPkt[REQ_W-1];
                r_threadIdx   <= w_reqPkt[REQ_W-2 -: THREAD_IDX_W];
                io_address    <= w_reqPkt[63:32];
                io_write_data <= w_reqPkt[31:0];
                io_write_en   <= w_reqPkt[REQ_W-1];
                io_read_en    <= !w_reqPkt[REQ_W-1];
            end
            if (r_state == WAIT_DATA) begin
                iorsp_valid  <= 1'b1;
                iorsp_packet <= {4'(r_grantIdx), r_threadIdx, (r_store ? 32'd0 : io_read_data)};
            end
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Testbench for io_bus_arbiter (4 ports): a vector table for single read/write
// and overlap, hand sequences for round-robin, pointer wrap, back-to-back and
// reset abort, then randomized traffic checked against a transaction model.

module tb_io_bus_arbiter;
    localparam int N     = 4;
    localparam int TW    = 2;
    localparam int REQ_W = 1 + TW + 64;
    localparam int RSP_W = 4 + TW + 32;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       ioreq_valid;
    logic [N*REQ_W-1:0] ioreq_packet;
    logic [N-1:0]       ioreq_ready;
    logic               iorsp_valid;
    logic [RSP_W-1:0]   iorsp_packet;
    logic               io_write_en;
    logic               io_read_en;
    logic [31:0]        io_address;
    logic [31:0]        io_write_data;
    logic [31:0]        io_read_data;

    io_bus_arbiter #(.NUM_REQUESTERS(N), .THREAD_IDX_W(TW)) dut (
        .clk(clk), .reset(reset),
        .ioreq_valid(ioreq_valid), .ioreq_packet(ioreq_packet), .ioreq_ready(ioreq_ready),
        .iorsp_valid(iorsp_valid), .iorsp_packet(iorsp_packet),
        .io_write_en(io_write_en), .io_read_en(io_read_en),
        .io_address(io_address), .io_write_data(io_write_data), .io_read_data(io_read_data)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic        store;
        logic [1:0]  thr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  expReady;
        logic        expWr;
        logic        expRd;
        logic [31:0] expAddr;
        logic [31:0] expWdata;
        logic        expRspV;
        logic [3:0]  expCore;
        logic [1:0]  expThr;
        logic [31:0] expRval;
    } vec_t;

    int testsRun    = 0;
    int testsFailed = 0;
    int cycle       = 0;

    logic [REQ_W-1:0] pkt [N];
    logic [N-1:0]     lastReady;
    int               actGrant[$];
    int               actCycle[$];

    // Transaction-level reference: when the bus is free again, which cycle a
    // transaction is on the bus, which cycle its response appears.
    int          mPtr   = 0;
    int          mFree  = 0;
    int          mIssue = -10;
    int          mRsp   = -10;
    int          mCore  = 0;
    logic        mStore = 1'b0;
    logic [1:0]  mThr   = '0;
    logic [31:0] mAddr  = '0;
    logic [31:0] mData  = '0;
    logic [31:0] mRval  = '0;

    function automatic logic [REQ_W-1:0] mkPkt(input logic st, input logic [1:0] th,
                                               input logic [31:0] ad, input logic [31:0] va);
        return {st, th, ad, va};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", name, cycle, actual, expected);
        end
    endtask

    // Predict this cycle's outputs from the model, compare, then advance it.
    task automatic modelCycle();
        logic [N-1:0] expReady;
        logic         inIssue;
        int           g;
        logic [REQ_W-1:0] gp;
        expReady = '0;
        g = -1;
        if (!reset && cycle >= mFree) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && ioreq_valid[(mPtr + k) % N]) g = (mPtr + k) % N;
            end
        end
        if (g >= 0) expReady[g] = 1'b1;
        inIssue = (cycle == mIssue);
        checkOutput("model_ready", 64'(ioreq_ready), 64'(expReady));
        checkOutput("model_write_en", 64'(io_write_en), 64'(inIssue && mStore));
        checkOutput("model_read_en", 64'(io_read_en), 64'(inIssue && !mStore));
        if (inIssue) begin
            checkOutput("model_address", 64'(io_address), 64'(mAddr));
            if (mStore) checkOutput("model_write_data", 64'(io_write_data), 64'(mData));
        end
        checkOutput("model_rsp_valid", 64'(iorsp_valid), 64'(cycle == mRsp));
        if (cycle == mRsp)
            checkOutput("model_rsp_packet", 64'(iorsp_packet), 64'({4'(mCore), mThr, mRval}));
        if (reset) begin
            mPtr   = 0;
            mFree  = cycle + 1;
            mIssue = -10;
            mRsp   = -10;
        end else begin
            if (cycle == mIssue + 1 && !mStore) mRval = io_read_data;
            if (g >= 0) begin
                gp     = pkt[g];
                mStore = gp[REQ_W-1];
                mThr   = gp[REQ_W-2 -: TW];
                mAddr  = gp[63:32];
                mData  = gp[31:0];
                if (mStore) mRval = '0;
                mCore  = g;
                mPtr   = (g + 1) % N;
                mIssue = cycle + 1;
                mRsp   = cycle + 3;
                mFree  = cycle + 3;
            end
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then check just after.
    task automatic applyStimulus(input logic rst, input logic [N-1:0] valid, input logic [31:0] rdata);
        @(negedge clk);
        reset        = rst;
        ioreq_valid  = valid;
        io_read_data = rdata;
        for (int p = 0; p < N; p++) ioreq_packet[p*REQ_W +: REQ_W] = pkt[p];
        #1;
        modelCycle();
        lastReady = ioreq_ready;
        for (int p = 0; p < N; p++) begin
            if (ioreq_ready[p]) begin
                actGrant.push_back(p);
                actCycle.push_back(cycle);
            end
        end
        cycle++;
    endtask

    vec_t         tbl [11];
    int           order [5];
    logic [N-1:0] pending;
    logic         doRst;

    initial begin
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0,
                    4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 2'd0, 32'h0};
        tbl[1]  = '{1'b0, 4'b0100, 1'b0, 2'd1, 32'hFFFF0010, 32'h0, 32'h0,
                    4'b0100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 2'd0, 32'h0};
        tbl[2]  = '{1'b0, 4'b0000, 1'b0, 2'd1, 32'hFFFF0010, 32'h0, 32'h0,
                    4'b0000, 1'b0, 1'b1, 32'hFFFF0010, 32'h0, 1'b0, 4'd0, 2'd0, 32'h0};
        tbl[3]  = '{1'b0, 4'b0000, 1'b0, 2'd1, 32'hFFFF0010, 32'h0, 32'hDEADBEEF,
                    4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 2'd0, 32'h0};
        tbl[4]  = '{1'b0, 4'b0001, 1'b1, 2'd3, 32'hFFFF0004, 32'h12345678, 32'h0,
                    4'b0001, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 4'd2, 2'd1, 32'hDEADBEEF};
        tbl[5]  = '{1'b0, 4'b0000, 1'b1, 2'd3, 32'hFFFF0004, 32'h12345678, 32'hAAAA5555,
                    4'b0000, 1'b1, 1'b0, 32'hFFFF0004, 32'h12345678, 1'b0, 4'd0, 2'd0, 32'h0};
        tbl[6]  = '{1'b0, 4'b0000, 1'b1, 2'd3, 32'hFFFF0004, 32'h12345678, 32'hAAAA5555,
                    4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 2'd0, 32'h0};
        tbl[7]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 32'hFFFF0020, 32'h0, 32'h0,
                    4'b0010, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 4'd0, 2'd3, 32'h0};
        tbl[8]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 32'hFFFF0020, 32'h0, 32'h0,
                    4'b0000, 1'b0, 1'b1, 32'hFFFF0020, 32'h0, 1'b0, 4'd0, 2'd0, 32'h0};
        tbl[9]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 32'hFFFF0020, 32'h0, 32'h0BADF00D,
                    4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 2'd0, 32'h0};
        tbl[10] = '{1'b0, 4'b1111, 1'b0, 2'd0, 32'hFFFF0020, 32'h0, 32'h0,
                    4'b0100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 4'd1, 2'd0, 32'h0BADF00D};

        for (int p = 0; p < N; p++) pkt[p] = '0;
        reset        = 1'b1;
        ioreq_valid  = '0;
        ioreq_packet = '0;
        io_read_data = '0;
        lastReady    = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_ready", 64'(ioreq_ready), 64'd0);
        checkOutput("reset_enables", 64'({io_write_en, io_read_en, iorsp_valid}), 64'd0);
        checkOutput("reset_address", 64'(io_address), 64'd0);
        checkOutput("reset_write_data", 64'(io_write_data), 64'd0);
        checkOutput("reset_rsp_packet", 64'(iorsp_packet), 64'd0);

        // Vector table: single read, overlapping write accept, store response.
        for (int r = 0; r < 11; r++) begin
            for (int p = 0; p < N; p++) pkt[p] = mkPkt(tbl[r].store, tbl[r].thr, tbl[r].addr, tbl[r].wdata);
            applyStimulus(tbl[r].rst, tbl[r].valid, tbl[r].rdata);
            checkOutput("tbl_ready", 64'(ioreq_ready), 64'(tbl[r].expReady));
            checkOutput("tbl_write_en", 64'(io_write_en), 64'(tbl[r].expWr));
            checkOutput("tbl_read_en", 64'(io_read_en), 64'(tbl[r].expRd));
            checkOutput("tbl_rsp_valid", 64'(iorsp_valid), 64'(tbl[r].expRspV));
            if (tbl[r].expWr || tbl[r].expRd)
                checkOutput("tbl_address", 64'(io_address), 64'(tbl[r].expAddr));
            if (tbl[r].expWr)
                checkOutput("tbl_write_data", 64'(io_write_data), 64'(tbl[r].expWdata));
            if (tbl[r].expRspV)
                checkOutput("tbl_rsp_packet", 64'(iorsp_packet),
                            64'({tbl[r].expCore, tbl[r].expThr, tbl[r].expRval}));
        end

        // Round-robin from reset: all four ports hold valid.
        for (int p = 0; p < N; p++) pkt[p] = mkPkt(1'b0, 2'(p), 32'hFFFF0100 + 32'(p), 32'h0);
        applyStimulus(1'b1, 4'b0000, 32'h0);
        actGrant.delete();
        actCycle.delete();
        for (int i = 0; i < 13; i++) applyStimulus(1'b0, 4'b1111, 32'h1000 + 32'(i));
        order = '{0, 1, 2, 3, 0};
        checkOutput("rr_grant_count", 64'(actGrant.size()), 64'd5);
        if (actGrant.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                checkOutput("rr_grant_port", 64'(actGrant[i]), 64'(order[i]));
                if (i > 0) checkOutput("rr_grant_spacing", 64'(actCycle[i] - actCycle[i-1]), 64'd3);
            end
        end

        // Pointer wrap: port 3 granted, then 1 beats 3, then 0 after 3 drops.
        applyStimulus(1'b1, 4'b0000, 32'h0);
        applyStimulus(1'b0, 4'b1000, 32'h0);
        checkOutput("wrap_grant_p3", 64'(ioreq_ready), 64'b1000);
        applyStimulus(1'b0, 4'b1010, 32'h0);
        applyStimulus(1'b0, 4'b1010, 32'h0);
        applyStimulus(1'b0, 4'b1010, 32'h0);
        checkOutput("wrap_grant_p1", 64'(ioreq_ready), 64'b0010);
        applyStimulus(1'b0, 4'b0001, 32'h0);
        applyStimulus(1'b0, 4'b0001, 32'h0);
        applyStimulus(1'b0, 4'b0001, 32'h0);
        checkOutput("wrap_grant_p0", 64'(ioreq_ready), 64'b0001);

        // Back-to-back: port 2 holds valid; accepts at A, A+3, A+6.
        applyStimulus(1'b1, 4'b0000, 32'h0);
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b0, 4'b0100, 32'h5000 + 32'(i));
            if (i == 1 || i == 4 || i == 7) checkOutput("b2b_accept", 64'(ioreq_ready), 64'b0100);
            else                            checkOutput("b2b_idle", 64'(ioreq_ready), 64'b0000);
            if (i == 4 || i == 7)           checkOutput("b2b_rsp_overlap", 64'(iorsp_valid), 64'd1);
        end

        // Reset during ISSUE of a port-2 read aborts it and clears the pointer.
        applyStimulus(1'b1, 4'b0000, 32'h0);
        pkt[2] = mkPkt(1'b0, 2'd2, 32'hFFFF0030, 32'h0);
        applyStimulus(1'b0, 4'b0100, 32'h0);
        checkOutput("abort_accept", 64'(ioreq_ready), 64'b0100);
        applyStimulus(1'b1, 4'b0000, 32'h0);
        checkOutput("abort_issue_read_en", 64'(io_read_en), 64'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 4'b0000, 32'hCAFEF00D);
            if (i == 0) checkOutput("abort_read_en_dropped", 64'(io_read_en), 64'd0);
            checkOutput("abort_no_rsp", 64'(iorsp_valid), 64'd0);
        end
        applyStimulus(1'b0, 4'b1010, 32'h0);
        checkOutput("abort_ptr_cleared", 64'(ioreq_ready), 64'b0010);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b0000, 32'h77770000 + 32'(i));

        // Randomized traffic: requesters hold until granted, sometimes give up.
        pending = '0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < N; p++) begin
                if (!pending[p] && $urandom_range(2) == 0) begin
                    pending[p] = 1'b1;
                    pkt[p] = mkPkt(1'($urandom_range(1)), 2'($urandom_range(3)), $urandom, $urandom);
                end else if (pending[p] && $urandom_range(19) == 0) begin
                    pending[p] = 1'b0;
                end
            end
            doRst = ($urandom_range(99) == 0);
            applyStimulus(doRst, pending, $urandom);
            pending = pending & ~lastReady;
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
